// File: rtl/vga_timing_pkg.sv
// Shared types, 640x480@60 default timings and total-length helpers for the VGA timing controller.
package vga_timing_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} vtc_state_t;

    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_FETCH_LAT = 2;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register that aligns de/sync with the pixel data returned by the fetch pipeline.
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clkp,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clkp or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing sequencer: fetch requests lead de/hsync/vsync by FETCH_LAT cycles; frames always complete.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int FETCH_LAT = DEF_FETCH_LAT
) (
    input  logic       clkp,
    input  logic       rst_n,
    input  logic       enable,
    output logic       fetch_req,
    output logic [9:0] fetch_x,
    output logic [9:0] fetch_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running,
    output logic       de,
    output logic       hsync,
    output logic       vsync
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    vtc_state_t state, state_nxt;
    logic [9:0] h_cnt, v_cnt;
    logic       at_end;
    logic       active;
    logic       hs_raw, vs_raw;
    logic       hs_f, vs_f;
    logic [2:0] dl_q;

    assign at_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT) && (state != IDLE);
    assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    always_ff @(posedge clkp or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // DRAIN only drops to IDLE on the very last pixel, so a frame is never cut short.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable)      state_nxt = RUN;
                else if (at_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clkp or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_ff @(posedge clkp or negedge rst_n) begin
        if (!rst_n) begin
            fetch_req   <= 1'b0;
            fetch_x     <= '0;
            fetch_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            hs_f        <= 1'b0;
            vs_f        <= 1'b0;
        end else begin
            fetch_req   <= active;
            line_start  <= active && (h_cnt == 10'd0);
            frame_start <= active && (h_cnt == 10'd0) && (v_cnt == 10'd0);
            hs_f        <= hs_raw;
            vs_f        <= vs_raw;
            if (active) begin
                fetch_x <= h_cnt;
                fetch_y <= v_cnt;
            end
        end
    end

    vga_delay_line #(
        .DEPTH(FETCH_LAT),
        .WIDTH(3)
    ) u_delay (
        .clkp (clkp),
        .rst_n(rst_n),
        .d    ({fetch_req, hs_f, vs_f}),
        .q    (dl_q)
    );

    assign de      = dl_q[2];
    assign hsync   = dl_q[1] ? H_POL : ~H_POL;
    assign vsync   = dl_q[0] ? V_POL : ~V_POL;
    assign running = (state != IDLE);

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clkp or negedge rst_n) begin
        if (!rst_n)           frame_cnt <= '0;
        else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized self-checking bench for vga_timing_ctrl using reduced timings and a position-arithmetic model.
module tb_vga_timing_ctrl;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int FL = 3;
    localparam bit HPOL = 1'b0, VPOL = 1'b0;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic       clkp = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fetch_req, line_start, frame_start, running, de, hsync, vsync;
    logic [9:0] fetch_x, fetch_y;
    logic [7:0] fc_act;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt;
    assign fc_act = frame_cnt;
`else
    assign fc_act = 8'd0;
`endif

    int total = 0;
    int bad = 0;
    int tnow = 0;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(HPOL), .V_POL(VPOL), .FETCH_LAT(FL)
    ) dut (
        .clkp(clkp), .rst_n(rst_n), .enable(enable),
        .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y),
        .line_start(line_start), .frame_start(frame_start), .running(running),
        .de(de), .hsync(hsync), .vsync(vsync)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clkp = ~clkp;
    always @(posedge clkp) tnow++;

    // Reference: the scan position is just the cycle offset since counting began, split by div/mod.
    logic       m_on, m_en_d;
    int         m_pos;
    logic       e_req, e_ls, e_fs, e_hs, e_vs, e_run;
    logic [9:0] e_x, e_y;
    logic [2:0] e_dl [FL];
    logic [7:0] e_fc;

    always @(posedge clkp or negedge rst_n) begin
        int  x, y;
        logic act;
        if (!rst_n) begin
            m_on = 0; m_en_d = 0; m_pos = 0;
            e_req = 0; e_ls = 0; e_fs = 0; e_hs = 0; e_vs = 0; e_run = 0;
            e_x = 0; e_y = 0; e_fc = 0;
            for (int i = 0; i < FL; i++) e_dl[i] = 3'b000;
        end else begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (e_fs) e_fc = e_fc + 8'd1;
`endif
            for (int i = FL - 1; i > 0; i--) e_dl[i] = e_dl[i-1];
            e_dl[0] = {e_req, e_hs, e_vs};
            x = m_on ? m_pos % HT : 0;
            y = m_on ? (m_pos / HT) % VT : 0;
            act = m_on && (x < HA) && (y < VA);
            e_req = act;
            e_ls = act && (x == 0);
            e_fs = act && (x == 0) && (y == 0);
            if (act) begin
                e_x = 10'(x);
                e_y = 10'(y);
            end
            e_hs = (x >= HA + HFP) && (x < HA + HFP + HS);
            e_vs = (y >= VA + VFP) && (y < VA + VFP + VS);
            // A frame ends in IDLE only if enable was low both entering and leaving its final pixel.
            if (!m_on) begin
                if (enable) begin
                    m_on = 1;
                    m_pos = 0;
                end
            end else if ((m_pos % FRAME == FRAME - 1) && !enable && !m_en_d) begin
                m_on = 0;
            end else begin
                m_pos++;
            end
            m_en_d = enable;
            e_run = m_on;
        end
    end

    logic [34:0] act_vec, exp_vec;
    assign act_vec = {fetch_req, line_start, frame_start, fetch_x, fetch_y, running, de, hsync, vsync, fc_act};
    assign exp_vec = {e_req, e_ls, e_fs, e_x, e_y, e_run, e_dl[FL-1][2],
                      (e_dl[FL-1][1] ? HPOL : ~HPOL), (e_dl[FL-1][0] ? VPOL : ~VPOL), e_fc};

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clkp);
        total++; if (fetch_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_fetch_req actual=%b expected=0", fetch_req); end
        total++; if (de !== 1'b0) begin bad++; $display("[TB] FAIL reset_de actual=%b expected=0", de); end
        total++; if (hsync !== ~HPOL) begin bad++; $display("[TB] FAIL reset_hsync actual=%b expected=%b", hsync, ~HPOL); end
        total++; if (vsync !== ~VPOL) begin bad++; $display("[TB] FAIL reset_vsync actual=%b expected=%b", vsync, ~VPOL); end
        total++; if (running !== 1'b0) begin bad++; $display("[TB] FAIL reset_running actual=%b expected=0", running); end
        total++; if ({fetch_x, fetch_y} !== 20'd0) begin bad++; $display("[TB] FAIL reset_xy actual=%0d,%0d expected=0,0", fetch_x, fetch_y); end
        total++; if ({line_start, frame_start} !== 2'b00) begin bad++; $display("[TB] FAIL reset_pulses actual=%b expected=00", {line_start, frame_start}); end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL idle_hold actual=%h expected=%h", act_vec, exp_vec); end
        end
    endtask

    task automatic test_frame_timing();
        int  t_fs0, t_fs1, t_de_rise, t_de_fall, t_hs_fall, t_hs_rise, t_vs_fall, t_vs_rise, de_lines;
        logic de_p, hs_p, vs_p, got;
        t_fs0 = -1; t_fs1 = -1; t_de_rise = -1; t_de_fall = -1;
        t_hs_fall = -1; t_hs_rise = -1; t_vs_fall = -1; t_vs_rise = -1; de_lines = 0;
        enable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL start_wait actual=%h expected=%h", act_vec, exp_vec); end
            if (frame_start) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("[TB] FAIL start_timeout actual=no frame_start expected=frame_start within 10 cycles"); end
        total++;
        if ({fetch_req, line_start, fetch_x, fetch_y} !== {2'b11, 20'd0}) begin
            bad++; $display("[TB] FAIL start_first_pixel actual=req%b ls%b (%0d,%0d) expected=req1 ls1 (0,0)", fetch_req, line_start, fetch_x, fetch_y);
        end
        t_fs0 = tnow;
        de_p = de; hs_p = hsync; vs_p = vsync;
        for (int i = 0; i < FRAME + 2 * HT; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL frame_run actual=%h expected=%h t=%0d", act_vec, exp_vec, tnow); end
            if (frame_start && t_fs1 < 0) t_fs1 = tnow;
            if (de && !de_p) begin
                if (t_de_rise < 0) t_de_rise = tnow;
                if (tnow < t_fs0 + FRAME) de_lines++;
            end
            if (!de && de_p && t_de_fall < 0) t_de_fall = tnow;
            if (hs_p && !hsync && t_hs_fall < 0) t_hs_fall = tnow;
            if (!hs_p && hsync && t_hs_fall >= 0 && t_hs_rise < 0) t_hs_rise = tnow;
            if (vs_p && !vsync && t_vs_fall < 0) t_vs_fall = tnow;
            if (!vs_p && vsync && t_vs_fall >= 0 && t_vs_rise < 0) t_vs_rise = tnow;
            de_p = de; hs_p = hsync; vs_p = vsync;
        end
        total++; if (t_de_rise - t_fs0 !== FL) begin bad++; $display("[TB] FAIL de_latency actual=%0d expected=%0d", t_de_rise - t_fs0, FL); end
        total++; if (t_de_fall - t_de_rise !== HA) begin bad++; $display("[TB] FAIL de_width actual=%0d expected=%0d", t_de_fall - t_de_rise, HA); end
        total++; if (t_hs_fall - t_de_rise !== HA + HFP) begin bad++; $display("[TB] FAIL hsync_offset actual=%0d expected=%0d", t_hs_fall - t_de_rise, HA + HFP); end
        total++; if (t_hs_rise - t_hs_fall !== HS) begin bad++; $display("[TB] FAIL hsync_width actual=%0d expected=%0d", t_hs_rise - t_hs_fall, HS); end
        total++; if (t_vs_rise - t_vs_fall !== VS * HT) begin bad++; $display("[TB] FAIL vsync_width actual=%0d expected=%0d", t_vs_rise - t_vs_fall, VS * HT); end
        total++; if (t_vs_fall - t_de_rise !== (VA + VFP) * HT) begin bad++; $display("[TB] FAIL vsync_offset actual=%0d expected=%0d", t_vs_fall - t_de_rise, (VA + VFP) * HT); end
        total++; if (t_fs1 - t_fs0 !== FRAME) begin bad++; $display("[TB] FAIL frame_period actual=%0d expected=%0d", t_fs1 - t_fs0, FRAME); end
        total++; if (de_lines !== VA) begin bad++; $display("[TB] FAIL de_lines actual=%0d expected=%0d", de_lines, VA); end
    endtask

    task automatic test_stop();
        int  last_req, last_de;
        logic stopped;
        last_req = -1; last_de = -1; stopped = 1'b0;
        enable = 1'b1;
        repeat ($urandom_range(3 * HT, 6 * HT)) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL stop_pre actual=%h expected=%h", act_vec, exp_vec); end
        end
        enable = 1'b0;
        for (int i = 0; i < 2 * FRAME + 10 && !stopped; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL stop_drain actual=%h expected=%h t=%0d", act_vec, exp_vec, tnow); end
            if (fetch_req) last_req = tnow;
            if (de) last_de = tnow;
            if (!running) stopped = 1'b1;
        end
        total++;
        if (!stopped) begin bad++; $display("[TB] FAIL stop_timeout actual=running expected=idle"); end
        for (int i = 0; i < 4 * FL; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL stop_tail actual=%h expected=%h", act_vec, exp_vec); end
            if (de) last_de = tnow;
        end
        total++; if (last_de - last_req !== FL) begin bad++; $display("[TB] FAIL last_de_lag actual=%0d expected=%0d", last_de - last_req, FL); end
        total++;
        if ({de, hsync, vsync, fetch_req} !== {1'b0, ~HPOL, ~VPOL, 1'b0}) begin
            bad++; $display("[TB] FAIL idle_outputs actual=de%b hs%b vs%b req%b expected=de0 hs%b vs%b req0", de, hsync, vsync, fetch_req, ~HPOL, ~VPOL);
        end
        total++;
        if ({fetch_x, fetch_y} !== {10'(HA - 1), 10'(VA - 1)}) begin
            bad++; $display("[TB] FAIL held_xy actual=%0d,%0d expected=%0d,%0d", fetch_x, fetch_y, HA - 1, VA - 1);
        end
    endtask

    task automatic test_last_cycle_disable();
        int  run_cnt, fs_cnt;
        logic hit;
        run_cnt = 0; fs_cnt = 0; hit = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2 * FRAME + 10 && !hit; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL lastcyc_wait actual=%h expected=%h", act_vec, exp_vec); end
            if (m_on && (m_pos % FRAME == FRAME - 1)) hit = 1'b1;
        end
        total++;
        if (!hit) begin bad++; $display("[TB] FAIL lastcyc_timeout actual=no frame end expected=frame end"); end
        enable = 1'b0;
        for (int i = 0; i < FRAME + 5; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL lastcyc_drain actual=%h expected=%h", act_vec, exp_vec); end
            if (running) run_cnt++;
            if (frame_start) fs_cnt++;
        end
        total++; if (run_cnt !== FRAME) begin bad++; $display("[TB] FAIL lastcyc_run_len actual=%0d expected=%0d", run_cnt, FRAME); end
        total++; if (fs_cnt !== 1) begin bad++; $display("[TB] FAIL lastcyc_frames actual=%0d expected=1", fs_cnt); end
    endtask

    task automatic test_drain_resume();
        int  t0, t1;
        logic got;
        t0 = -1; t1 = -1; got = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL resume_wait actual=%h expected=%h", act_vec, exp_vec); end
            if (frame_start) begin got = 1'b1; t0 = tnow; end
        end
        repeat ($urandom_range(HT, 3 * HT)) @(negedge clkp);
        enable = 1'b0;
        repeat ($urandom_range(1, 4 * HT)) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL resume_drain actual=%h expected=%h", act_vec, exp_vec); end
        end
        enable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL resume_run actual=%h expected=%h", act_vec, exp_vec); end
            if (frame_start) begin got = 1'b1; t1 = tnow; end
        end
        total++; if (t1 - t0 !== FRAME) begin bad++; $display("[TB] FAIL resume_period actual=%0d expected=%0d", t1 - t0, FRAME); end
    endtask

    task automatic test_random_enable();
        for (int seg = 0; seg < 12; seg++) begin
            enable = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, FRAME)) begin
                @(negedge clkp);
                total++;
                if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL random_en actual=%h expected=%h seg=%0d", act_vec, exp_vec, seg); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic got;
        got = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            @(negedge clkp);
            if (fetch_req && de && fetch_x > 10'd4) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("[TB] FAIL areset_setup actual=no mid-line expected=mid-line"); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({fetch_req, line_start, frame_start, de, running} !== 5'b0) begin
            bad++; $display("[TB] FAIL areset_flags actual=%b expected=00000", {fetch_req, line_start, frame_start, de, running});
        end
        total++;
        if ({fetch_x, fetch_y, hsync, vsync} !== {20'd0, ~HPOL, ~VPOL}) begin
            bad++; $display("[TB] FAIL areset_vals actual=%0d,%0d hs%b vs%b expected=0,0 hs%b vs%b", fetch_x, fetch_y, hsync, vsync, ~HPOL, ~VPOL);
        end
        @(negedge clkp);
        rst_n = 1'b1;
        repeat (HT) begin
            @(negedge clkp);
            total++;
            if (act_vec !== exp_vec) begin bad++; $display("[TB] FAIL areset_restart actual=%h expected=%h", act_vec, exp_vec); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_stop();
        test_last_cycle_disable();
        test_drain_resume();
        test_random_enable();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
